// File: rtl/alu_result_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_result_stage
//  Purpose  : Execute-to-writeback stage behind the integer ALU. Each ALU
//             result is captured with its destination register into a
//             2-entry skid FIFO. Results leave in order toward the
//             register-file writeback port. A combinational forwarding
//             lookup exposes results that are still in flight.
//  Ports    : clk, rst (async, active-high), flush (sync)
//             in_valid/in_ready/in_result/in_rd/in_rd_we    - ALU side
//             out_valid/out_ready/out_result/out_rd/out_rd_we - writeback
//             fwd_rs -> fwd_hit/fwd_data                     - bypass lookup
//             stat_accepted/stat_stall                       - counters
//  Options  : ALU_RESULT_STAGE_STATS_EN enables the two statistics counters.
//             When it is undefined, both stat ports read as zero.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
   parameter int REG_LEN = 32,
   parameter int RD_W    = 5,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [REG_LEN-1:0] in_result,
   input  logic [RD_W-1:0]    in_rd,
   input  logic               in_rd_we,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [REG_LEN-1:0] out_result,
   output logic [RD_W-1:0]    out_rd,
   output logic               out_rd_we,
   input  logic [RD_W-1:0]    fwd_rs,
   output logic               fwd_hit,
   output logic [REG_LEN-1:0] fwd_data,
   output logic [31:0]        stat_accepted,
   output logic [31:0]        stat_stall
);

   // The shift-register organisation below only works for two entries.
   generate
      if (DEPTH != 2) begin : g_depth_check
         $error("alu_result_stage: DEPTH must be 2");
      end
   endgenerate

   logic [1:0]         count;
   logic [REG_LEN-1:0] res0, res1;
   logic [RD_W-1:0]    rd0, rd1;
   logic               we0, we1;

   logic push, pop, new_we, tail_is_0;
   logic hit0, hit1;

   // in_ready comes from registered state and rst only. There is no path from out_ready.
   assign in_ready  = (count != 2'd2) & ~rst;
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // A write to x0 is never emitted as a write.
   assign new_we    = in_rd_we & (in_rd != '0);

   // The tail slot is found after any pop in the same cycle has been applied.
   assign tail_is_0 = (count == 2'd0) | ((count == 2'd1) & pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 2'd0;
         res0  <= '0;
         res1  <= '0;
         rd0   <= '0;
         rd1   <= '0;
         we0   <= 1'b0;
         we1   <= 1'b0;
      end else if (flush) begin
         // A flush discards a push or pop presented in the same cycle.
         count <= 2'd0;
      end else begin
         if (pop) begin
            res0 <= res1;
            rd0  <= rd1;
            we0  <= we1;
         end
         // Placed after the shift, so that a push into slot 0 overrides it.
         if (push) begin
            if (tail_is_0) begin
               res0 <= in_result;
               rd0  <= in_rd;
               we0  <= new_we;
            end else begin
               res1 <= in_result;
               rd1  <= in_rd;
               we1  <= new_we;
            end
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // The head is masked to zero when the buffer is empty, so stale data is never visible.
   assign out_result = out_valid ? res0 : '0;
   assign out_rd     = out_valid ? rd0  : '0;
   assign out_rd_we  = out_valid & we0;

   // Forwarding: entry 1 is younger than entry 0, so entry 1 wins.
   assign hit0 = out_valid & we0 & (rd0 == fwd_rs) & (fwd_rs != '0);
   assign hit1 = (count == 2'd2) & we1 & (rd1 == fwd_rs) & (fwd_rs != '0);

   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (hit1) begin
         fwd_hit  = 1'b1;
         fwd_data = res1;
      end else if (hit0) begin
         fwd_hit  = 1'b1;
         fwd_data = res0;
      end
   end

`ifdef ALU_RESULT_STAGE_STATS_EN
   logic [31:0] accepted_cnt;
   logic [31:0] stall_cnt;

   // Only rst clears these counters; a flush does not. A push dropped by a flush is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accepted_cnt <= 32'd0;
         stall_cnt    <= 32'd0;
      end else begin
         if (push & ~flush) begin
            accepted_cnt <= accepted_cnt + 32'd1;
         end
         if (out_valid & ~out_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign stat_accepted = accepted_cnt;
   assign stat_stall    = stall_cnt;
`else
   assign stat_accepted = 32'd0;
   assign stat_stall    = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_stage
//  Purpose  : Self-checking bench for alu_result_stage. It uses a queue
//             scoreboard for in-flight results, plus directed steps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        we;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [4:0]  in_rd;
   logic        in_rd_we;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [4:0]  fwd_rs;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [31:0] stat_accepted;
   logic [31:0] stat_stall;

   int checks = 0;
   int errors = 0;

   entry_t      q[$];
   logic [31:0] m_acc   = 32'd0;
   logic [31:0] m_stall = 32'd0;

   always #5 clk = ~clk;

   alu_result_stage #(.REG_LEN(32), .RD_W(5), .DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_result     (in_result),
      .in_rd         (in_rd),
      .in_rd_we      (in_rd_we),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_rd        (out_rd),
      .out_rd_we     (out_rd_we),
      .fwd_rs        (fwd_rs),
      .fwd_hit       (fwd_hit),
      .fwd_data      (fwd_data),
      .stat_accepted (stat_accepted),
      .stat_stall    (stat_stall)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle. The outputs are sampled mid-cycle against the model. The model is then
   // advanced by what the next rising edge does, and the task returns on the falling edge.
   task automatic step();
      logic        exp_ready, exp_valid, exp_hit;
      logic [31:0] exp_data;
      entry_t      e;
      #1;
      if (rst) begin
         q.delete();
         m_acc   = 32'd0;
         m_stall = 32'd0;
      end
      exp_ready = !rst && (q.size() < 2);
      exp_valid = (q.size() != 0);
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         check("out_result", out_result, q[0].res);
         check("out_rd", out_rd, q[0].rd);
         check("out_rd_we", out_rd_we, q[0].we);
      end else begin
         check("out_idle_zero", {out_result, out_rd, out_rd_we}, 0);
      end
      exp_hit  = 1'b0;
      exp_data = 32'd0;
      if (fwd_rs != 5'd0) begin
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].we && q[i].rd == fwd_rs) begin
               exp_hit  = 1'b1;
               exp_data = q[i].res;
            end
         end
      end
      check("fwd_hit", fwd_hit, exp_hit);
      check("fwd_data", fwd_data, exp_data);
`ifdef ALU_RESULT_STAGE_STATS_EN
      check("stat_accepted", stat_accepted, m_acc);
      check("stat_stall", stat_stall, m_stall);
`else
      check("stat_tied_zero", {stat_accepted, stat_stall}, 0);
`endif
      if (!rst) begin
         if (exp_valid && !out_ready) m_stall = m_stall + 32'd1;
         if (flush) begin
            q.delete();
         end else begin
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
               e.res = in_result;
               e.rd  = in_rd;
               e.we  = in_rd_we && (in_rd != 5'd0);
               q.push_back(e);
               m_acc = m_acc + 32'd1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d, input logic w);
      in_valid  = v;
      in_result = r;
      in_rd     = d;
      in_rd_we  = w;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; fwd_rs = 5'd0;
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      step();
      rst = 1'b0;
      step();

      // Reset mid-operation with two entries buffered.
      drive(1'b1, 32'h11, 5'd1, 1'b1); step();
      drive(1'b1, 32'h22, 5'd2, 1'b1); step();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      check("full_before_rst", in_ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_in_ready", in_ready, 1'b0);
      check("async_rst_out_result", out_result, 32'd0);
      q.delete(); m_acc = 32'd0; m_stall = 32'd0;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      step();
      step();

      // Ordered flow with backpressure.
      out_ready = 1'b0;
      drive(1'b1, 32'hDEADBEEF, 5'd3, 1'b1); step();
      drive(1'b1, 32'h12345678, 5'd4, 1'b1); step();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      check("bp_full_in_ready", in_ready, 1'b0);
      check("bp_head_first", out_result, 32'hDEADBEEF);
      out_ready = 1'b1;
      step();
      check("bp_ready_after_pop", in_ready, 1'b1);
      check("bp_head_second", out_result, 32'h12345678);
      step();
      step();

      // Streaming: one push and one pop per cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, i, 5'(i + 1), 1'b1);
         step();
      end
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      step();
      step();

      // Writes to x0, and forwarding.
      out_ready = 1'b0;
      drive(1'b1, 32'h5, 5'd0, 1'b1); step();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      fwd_rs = 5'd0;
      check("x0_we_dropped", out_rd_we, 1'b0);
      check("x0_no_fwd", fwd_hit, 1'b0);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      drive(1'b1, 32'hA, 5'd7, 1'b1); step();
      drive(1'b1, 32'hB, 5'd7, 1'b1); step();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      fwd_rs = 5'd7;
      #1;
      check("fwd_young_hit", fwd_hit, 1'b1);
      check("fwd_young_data", fwd_data, 32'hB);
      step();
      fwd_rs = 5'd8; step();
      out_ready = 1'b1; fwd_rs = 5'd7; step();
      step();
      fwd_rs = 5'd0;

      // A flush collides with a push and a pop.
      out_ready = 1'b0;
      drive(1'b1, 32'h100, 5'd9, 1'b1); step();
      drive(1'b1, 32'h200, 5'd10, 1'b1); step();
      drive(1'b1, 32'h300, 5'd11, 1'b1);
      out_ready = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      step();
      step();

      // Statistics: three pushes and four stalled cycles, then a flush, then a reset.
      rst = 1'b1; step(); rst = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 32'h1, 5'd1, 1'b1); step();
      drive(1'b1, 32'h2, 5'd2, 1'b0); step();
      drive(1'b0, 32'd0, 5'd0, 1'b0); step(); step();
      out_ready = 1'b1; step();
      out_ready = 1'b0;
      drive(1'b1, 32'h3, 5'd3, 1'b1); step();
      drive(1'b0, 32'd0, 5'd0, 1'b0);
      out_ready = 1'b1; flush = 1'b1; step();
      flush = 1'b0;
`ifdef ALU_RESULT_STAGE_STATS_EN
      check("stat_acc_after_flush", stat_accepted, 32'd3);
      check("stat_stall_after_flush", stat_stall, 32'd4);
`else
      check("stat_acc_off", stat_accepted, 32'd0);
      check("stat_stall_off", stat_stall, 32'd0);
`endif
      step();
      rst = 1'b1;
      #1;
      check("stat_acc_rst", stat_accepted, 32'd0);
      check("stat_stall_rst", stat_stall, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      q.delete(); m_acc = 32'd0; m_stall = 32'd0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
